uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 139 +++++++++++++
 tb/tb_uart_tx_arb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Two-requester round-robin arbiter feeding a single UART transmitter.
// Define UART_TX_ARB_TIMEOUT_EN to add a frame watchdog that raises a sticky tx_err.
module uart_tx_arb #(
   parameter logic [17:0] TIMEOUT_CYC = 18'd200000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_valid,
   input  logic [7:0] req_byte0,
   input  logic [7:0] req_byte1,
   output logic [1:0] req_ready,
   output logic [7:0] tx_byte,
   output logic       tx_en,
   input  logic       tx_ready,
   output logic       busy,
   output logic       grant_id,
   output logic       tx_err
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      SEND,
      DONE
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [1:0] ready_d;
   logic [7:0] byte_d;
   logic       tx_en_d;
   logic       gid_d;
   logic       last_q;
   logic       last_d;
   logic       timeout_hit;

`ifdef UART_TX_ARB_TIMEOUT_EN
   logic [17:0] cnt_q;
   logic        err_q;

   // The watchdog fires on the cycle whose increment would reach TIMEOUT_CYC.
   assign timeout_hit = ((state_q == START) || (state_q == SEND)) &&
                        ((cnt_q + 18'd1) == TIMEOUT_CYC);
   assign tx_err      = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         if ((state_q == IDLE) && (state_d == START)) begin
            cnt_q <= '0;
         end else if ((state_q == START) || (state_q == SEND)) begin
            cnt_q <= cnt_q + 18'd1;
         end
         if (timeout_hit) begin
            err_q <= 1'b1;
         end
      end
   end
`else
   logic unused_timeout;

   assign timeout_hit    = 1'b0;
   assign tx_err         = 1'b0;
   assign unused_timeout = ^TIMEOUT_CYC;
`endif

   assign busy = (state_q != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         req_ready <= 2'b00;
         tx_byte   <= 8'h00;
         tx_en     <= 1'b0;
         grant_id  <= 1'b0;
         last_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         req_ready <= ready_d;
         tx_byte   <= byte_d;
         tx_en     <= tx_en_d;
         grant_id  <= gid_d;
         last_q    <= last_d;
      end
   end

   // IDLE spends one cycle choosing a winner and one cycle presenting req_ready;
   // the byte is only taken if the winner is still valid during that pulse.
   always_comb begin
      state_d = state_q;
      ready_d = 2'b00;
      byte_d  = tx_byte;
      tx_en_d = 1'b0;
      gid_d   = grant_id;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (req_ready != 2'b00) begin
               if ((req_valid & req_ready) != 2'b00) begin
                  state_d = START;
                  tx_en_d = 1'b1;
                  gid_d   = req_ready[1];
                  last_d  = req_ready[1];
                  byte_d  = req_ready[1] ? req_byte1 : req_byte0;
               end
            end else if (req_valid == 2'b11) begin
               ready_d = last_q ? 2'b01 : 2'b10;
            end else begin
               ready_d = req_valid;
            end
         end
         START: begin
            tx_en_d = 1'b1;
            if (timeout_hit) begin
               state_d = DONE;
               tx_en_d = 1'b0;
            end else if (!tx_ready) begin
               state_d = SEND;
            end
         end
         SEND: begin
            tx_en_d = 1'b1;
            if (timeout_hit || tx_ready) begin
               state_d = DONE;
               tx_en_d = 1'b0;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: predicted frames are queued at request time
// and compared when tx_en rises; a transmitter model drives tx_ready.
module tb_uart_tx_arb;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int HOLD_CYC = 30;
`else
   localparam int HOLD_CYC = 100;
`endif
   localparam int DROP_CYC = 5;
   localparam int BOUND    = 400;

   typedef struct {
      logic       gid;
      logic [7:0] data;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [1:0] req_valid;
   logic [7:0] req_byte0;
   logic [7:0] req_byte1;
   logic [1:0] req_ready;
   logic [7:0] tx_byte;
   logic       tx_en;
   logic       tx_ready = 1'b1;
   logic       busy;
   logic       grant_id;
   logic       tx_err;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   logic model_ptr = 1'b1;
   logic xmit_on = 1'b1;
   logic prev_en = 1'b0;
   int   phase = 0;
   int   xcnt = 0;

   uart_tx_arb #(.TIMEOUT_CYC(18'd50)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_byte0(req_byte0),
      .req_byte1(req_byte1),
      .req_ready(req_ready),
      .tx_byte  (tx_byte),
      .tx_en    (tx_en),
      .tx_ready (tx_ready),
      .busy     (busy),
      .grant_id (grant_id),
      .tx_err   (tx_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives a request and queues the frames the arbiter should produce for it.
   task automatic applyStimulus(input logic [1:0] v, input logic [7:0] b0,
                                input logic [7:0] b1, input int frames);
      logic g;
      req_valid = v;
      req_byte0 = b0;
      req_byte1 = b1;
      for (int k = 0; k < frames; k++) begin
         g = (v == 2'b11) ? ~model_ptr : v[1];
         exp_q.push_back('{gid: g, data: (g ? b1 : b0)});
         model_ptr = g;
      end
   endtask

   task automatic waitGrant(input logic [1:0] exp_onehot, input string tag);
      bit found = 0;
      for (int i = 0; i < BOUND && !found; i++) begin
         tick();
         if (req_ready != 2'b00) found = 1;
      end
      if (!found) begin
         checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         checkOutput(tag, {30'd0, req_ready}, {30'd0, exp_onehot});
         tick();
         checkOutput({tag, "_pulse"}, {30'd0, req_ready}, 32'd0);
      end
   endtask

   task automatic waitIdle(input string tag);
      bit idle = 0;
      for (int i = 0; i < BOUND && !idle; i++) begin
         tick();
         if (!busy) idle = 1;
      end
      checkOutput(tag, {31'd0, idle}, 32'd1);
   endtask

   // Transmitter model: drop tx_ready DROP_CYC cycles into a frame, raise it HOLD_CYC later.
   always @(negedge clk) begin
      if (!rst_n || !xmit_on) begin
         phase    = 0;
         xcnt     = 0;
         tx_ready = 1'b1;
      end else begin
         case (phase)
            0: if (tx_en) begin phase = 1; xcnt = 0; end
            1: begin
               xcnt++;
               if (xcnt == DROP_CYC) begin tx_ready = 1'b0; phase = 2; xcnt = 0; end
            end
            2: begin
               xcnt++;
               if (xcnt == HOLD_CYC) begin tx_ready = 1'b1; phase = 3; end
            end
            default: if (!tx_en) phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst_n && tx_en && !prev_en) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_frame", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("frame_byte", {24'd0, tx_byte}, {24'd0, e.data});
            checkOutput("frame_gid", {31'd0, grant_id}, {31'd0, e.gid});
         end
      end
      prev_en = tx_en;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog observed=hang expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit   seen_low;
      logic last_en;
      int   cycles;
      rst_n     = 1'b0;
      req_valid = 2'b00;
      req_byte0 = 8'h00;
      req_byte1 = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_tx_en", {31'd0, tx_en}, 32'd0);
      checkOutput("rst_ready", {30'd0, req_ready}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_gid", {31'd0, grant_id}, 32'd0);
      checkOutput("rst_byte", {24'd0, tx_byte}, 32'd0);
      checkOutput("rst_err", {31'd0, tx_err}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Single request with exact latency, then completion timing.
      applyStimulus(2'b01, 8'h55, 8'h00, 1);
      tick();
      checkOutput("single_ready", {30'd0, req_ready}, 32'd1);
      checkOutput("single_en_early", {31'd0, tx_en}, 32'd0);
      tick();
      checkOutput("single_en", {31'd0, tx_en}, 32'd1);
      checkOutput("single_ready_off", {30'd0, req_ready}, 32'd0);
      checkOutput("single_byte", {24'd0, tx_byte}, 32'h55);
      checkOutput("single_gid", {31'd0, grant_id}, 32'd0);
      checkOutput("single_busy", {31'd0, busy}, 32'd1);
      req_valid = 2'b00;
      seen_low  = 0;
      last_en   = 1'b0;
      cycles    = 0;
      while (cycles < BOUND && !(seen_low && tx_ready)) begin
         tick();
         cycles++;
         if (!tx_ready) begin seen_low = 1; last_en = tx_en; end
      end
      checkOutput("txready_rise_seen", {31'd0, seen_low && tx_ready}, 32'd1);
      checkOutput("en_before_rise", {31'd0, last_en}, 32'd1);
      checkOutput("en_after_rise", {31'd0, tx_en}, 32'd0);
      checkOutput("busy_in_done", {31'd0, busy}, 32'd1);
      tick();
      checkOutput("busy_after_done", {31'd0, busy}, 32'd0);

      // Lone requester 0 wins although it was granted last; later input changes are ignored.
      applyStimulus(2'b01, 8'h3C, 8'h00, 1);
      waitGrant(2'b01, "lone_req0");
      req_valid = 2'b00;
      req_byte0 = 8'hFF;
      repeat (3) tick();
      checkOutput("hold_byte", {24'd0, tx_byte}, 32'h3C);
      checkOutput("hold_en", {31'd0, tx_en}, 32'd1);
      waitIdle("idle_after_lone");

      // Reset in the middle of SEND.
      applyStimulus(2'b10, 8'h00, 8'h77, 1);
      waitGrant(2'b10, "pre_reset_req1");
      req_valid = 2'b00;
      cycles    = 0;
      while (cycles < BOUND && tx_ready) begin tick(); cycles++; end
      repeat (2) tick();
      checkOutput("pre_reset_en", {31'd0, tx_en}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_en", {31'd0, tx_en}, 32'd0);
      checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
      checkOutput("midrst_byte", {24'd0, tx_byte}, 32'd0);
      checkOutput("midrst_gid", {31'd0, grant_id}, 32'd0);
      checkOutput("midrst_ready", {30'd0, req_ready}, 32'd0);
      model_ptr = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      applyStimulus(2'b10, 8'h00, 8'h9E, 1);
      waitGrant(2'b10, "post_reset_req1");
      req_valid = 2'b00;
      waitIdle("idle_after_reset");

      // Contention: both held for four frames, grants must alternate.
      applyStimulus(2'b11, 8'hA1, 8'hB2, 4);
      for (int k = 0; k < 4; k++) begin
         waitGrant((k % 2 == 0) ? 2'b01 : 2'b10, "contend");
      end
      req_valid = 2'b00;
      waitIdle("idle_after_contend");

      // Transmitter never responds.
      xmit_on = 1'b0;
      applyStimulus(2'b01, 8'h42, 8'h00, 1);
      waitGrant(2'b01, "stall_req0");
      req_valid = 2'b00;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cycles = 0;
      while (cycles < BOUND && tx_en) begin tick(); cycles++; end
      checkOutput("timeout_cycles", cycles, 32'd50);
      checkOutput("timeout_busy", {31'd0, busy}, 32'd1);
      checkOutput("timeout_err", {31'd0, tx_err}, 32'd1);
      tick();
      checkOutput("timeout_idle", {31'd0, busy}, 32'd0);
      xmit_on = 1'b1;
      applyStimulus(2'b10, 8'h00, 8'h5A, 1);
      waitGrant(2'b10, "after_timeout");
      req_valid = 2'b00;
      waitIdle("idle_after_timeout");
      checkOutput("err_sticky", {31'd0, tx_err}, 32'd1);
`else
      repeat (1000) tick();
      checkOutput("stall_en", {31'd0, tx_en}, 32'd1);
      checkOutput("stall_busy", {31'd0, busy}, 32'd1);
      checkOutput("stall_err", {31'd0, tx_err}, 32'd0);
      checkOutput("stall_ready", {30'd0, req_ready}, 32'd0);
`endif
      checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
